ppe_rr_scheduler: RTL

Round-robin grant scheduler built around the combinational programmable priority encoder `ppe_w1024`. It holds up to 1024 pending requests in a sticky pending vector and drives the encoder from registered request and pointer snapshots. It issues one grant at a time over a valid/ready handshake, then advances the rotating priority pointer past the granted index. It is the resource-sharing front end for any 1024-requester datapath that uses the PPE.

---
 rtl/ppe_sched_pkg.sv | 15 +
 rtl/ppe_w1024.sv | 47 ++++
 rtl/ppe_rr_scheduler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ppe_sched_pkg.sv
// Shared definitions for the round-robin PPE scheduler.
// Holds the default requester count and index width, plus the
// scheduler state enumeration used by the top-level FSM.
package ppe_sched_pkg;

    localparam int WIDTH_DEFAULT = 1024;
    localparam int PW_DEFAULT    = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        GRANT = 2'd2
    } sched_state_e;

endpackage

// File: rtl/ppe_w1024.sv
// Combinational programmable priority encoder.
// Returns the lowest set request index at or above ptr_i; if none exists
// it wraps around and returns the lowest set index overall.
// Ports:
//   req_i   - request vector
//   ptr_i   - priority base index
//   idx_o   - selected index (0 when nothing is set)
//   valid_o - 1 when at least one request bit is set
module ppe_w1024
    import ppe_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int PW    = PW_DEFAULT
) (
    input  logic [WIDTH-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [PW-1:0]    idx_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] upper;
    logic [PW-1:0]    idxUpper;
    logic [PW-1:0]    idxAll;
    logic             foundUpper;

    // Search the requests at or above the pointer first; the unmasked
    // search provides the wrap-around answer when that region is empty.
    // Scanning downwards lets the last hit be the lowest index.
    always_comb begin
        upper      = req_i & ({WIDTH{1'b1}} << ptr_i);
        idxUpper   = '0;
        idxAll     = '0;
        foundUpper = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (upper[i]) begin
                idxUpper   = PW'(i);
                foundUpper = 1'b1;
            end
            if (req_i[i]) begin
                idxAll = PW'(i);
            end
        end
        idx_o   = foundUpper ? idxUpper : idxAll;
        valid_o = |req_i;
    end

endmodule

// File: rtl/ppe_rr_scheduler.sv
// Round-robin grant scheduler in front of the ppe_w1024 encoder.
// Collects sticky requests, snapshots them together with a priority
// pointer, lets the encoder pick one, and offers it on a valid/ready
// handshake. The rotating pointer moves past each accepted grant.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   req_set     - per-requester set pulses into the pending vector
//   rr_en       - 1: rotating pointer, 0: fixed base cfg_ptr
//   cfg_ptr     - fixed priority base
//   gnt_valid   - grant offered
//   gnt_idx     - granted requester index
//   gnt_ready   - consumer accepts the grant
//   pending_any - registered OR of the pending vector
//   busy        - scheduler is not idle
module ppe_rr_scheduler
    import ppe_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int PW    = PW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_set,
    input  logic             rr_en,
    input  logic [PW-1:0]    cfg_ptr,
    output logic             gnt_valid,
    output logic [PW-1:0]    gnt_idx,
    input  logic             gnt_ready,
    output logic             pending_any,
    output logic             busy
);

    sched_state_e     state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] req_snap_q, req_snap_d;
    logic [PW-1:0]    ptr_snap_q, ptr_snap_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             pending_any_q;
    logic             accept;
    logic [WIDTH-1:0] clr_mask;
    logic [PW-1:0]    enc_idx;
    logic             enc_valid;

    ppe_w1024 #(
        .WIDTH (WIDTH),
        .PW    (PW)
    ) u_enc (
        .req_i   (req_snap_q),
        .ptr_i   (ptr_snap_q),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    // Next-state logic. Set pulses are OR-ed in after the clear so a bit
    // that is granted and re-requested in the same cycle stays pending.
    // The encoder only ever sees the snapshots, so new requests cannot
    // disturb a grant that is already being evaluated or offered.
    always_comb begin
        state_d     = state_q;
        req_snap_d  = req_snap_q;
        ptr_snap_d  = ptr_snap_q;
        ptr_d       = ptr_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;

        accept    = gnt_valid_q && gnt_ready;
        clr_mask  = accept ? (WIDTH'(1) << gnt_idx_q) : '0;
        pending_d = (pending_q & ~clr_mask) | req_set;

        case (state_q)
            IDLE: begin
                if (pending_any_q) begin
                    req_snap_d = pending_q;
                    ptr_snap_d = rr_en ? ptr_q : cfg_ptr;
                    state_d    = EVAL;
                end
            end
            EVAL: begin
                // An empty snapshot cannot occur because IDLE only leaves
                // on a non-empty pending vector; fall back to IDLE anyway.
                if (enc_valid) begin
                    gnt_idx_d   = enc_idx;
                    gnt_valid_d = 1'b1;
                    state_d     = GRANT;
                end else begin
                    gnt_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            GRANT: begin
                if (accept) begin
                    ptr_d       = (gnt_idx_q == PW'(WIDTH - 1)) ? '0 : gnt_idx_q + PW'(1);
                    gnt_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                gnt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; reset also drops any coincident requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            req_snap_q    <= '0;
            ptr_snap_q    <= '0;
            ptr_q         <= '0;
            gnt_idx_q     <= '0;
            gnt_valid_q   <= 1'b0;
            pending_any_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            req_snap_q    <= req_snap_d;
            ptr_snap_q    <= ptr_snap_d;
            ptr_q         <= ptr_d;
            gnt_idx_q     <= gnt_idx_d;
            gnt_valid_q   <= gnt_valid_d;
            pending_any_q <= |pending_d;
        end
    end

    assign gnt_valid   = gnt_valid_q;
    assign gnt_idx     = gnt_idx_q;
    assign pending_any = pending_any_q;
    assign busy        = (state_q != IDLE);

endmodule
